// File: rtl/prg_cache.sv
// Direct-mapped program cache: 64 lines x 4 half-words, one-cycle lookup,
// single outstanding line fill from memory with flush support.
module prg_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] prg_address,
    input  logic        flush,
    output logic [15:0] instruction,
    output logic        p_cache_miss,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_valid,
    input  logic [15:0] mem_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_FILL   = 2'd2;
    localparam logic [1:0] S_RESUME = 2'd3;

    logic [1:0]  r_state;
    logic [63:0] r_valid;
    logic [23:0] r_tag [0:63];
    logic [15:0] r_data [0:255];
    logic [31:0] r_addr_p0;
    logic [31:0] r_miss_addr;
    logic [1:0]  r_beat_cnt;
    logic        r_flush_pending;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [15:0] r_instr_p0;
    logic        r_armed;

    logic [31:0] w_lk_addr;
    logic        w_hit;
    logic        w_miss;
    logic        w_fill_beat;
    logic        w_last_beat;

    // Outside IDLE the arrays are steered to the line being filled, so the
    // RESUME cycle re-reads it and the next IDLE cycle sees a hit.
    assign w_lk_addr   = (r_state == S_IDLE) ? prg_address : r_miss_addr;
    assign w_hit       = r_valid[r_addr_p0[7:2]] && (r_tag[r_addr_p0[7:2]] == r_addr_p0[31:8]);
    assign w_miss      = r_armed && !w_hit;
    assign w_fill_beat = (r_state == S_FILL) && mem_valid;
    assign w_last_beat = w_fill_beat && (r_beat_cnt == 2'd3);

    assign instruction  = r_instr_p0;
    assign p_cache_miss = (r_state == S_IDLE) ? w_miss : 1'b1;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;

    // Stage p0: array read and registered lookup address
    always_ff @(posedge clk) begin
        r_addr_p0 <= w_lk_addr;
        if (!rst && w_fill_beat) begin
            r_data[{r_miss_addr[7:2], r_beat_cnt}] <= mem_data;
        end
        if (!rst && w_last_beat) begin
            r_tag[r_miss_addr[7:2]] <= r_miss_addr[31:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_p0 <= 16'h0000;
            r_armed    <= 1'b0;
        end else begin
            r_instr_p0 <= r_data[w_lk_addr[7:0]];
            r_armed    <= 1'b1;
        end
    end

    // A flush landing on the final beat wins over validating the new line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 64'd0;
        end else if (flush) begin
            r_valid <= 64'd0;
        end else if (w_last_beat && !r_flush_pending) begin
            r_valid[r_miss_addr[7:2]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_beat_cnt      <= 2'd0;
            r_flush_pending <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_miss_addr <= r_addr_p0;
                        r_mem_addr  <= {r_addr_p0[31:2], 2'b00};
                        r_mem_req   <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_valid) begin
                        r_beat_cnt <= r_beat_cnt + 2'd1;
                        if (r_beat_cnt == 2'd3) begin
                            r_state <= S_RESUME;
                        end
                    end
                end
                S_RESUME: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_last_beat) begin
                r_flush_pending <= 1'b0;
            end else if (flush && ((r_state == S_REQ) || (r_state == S_FILL))) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

endmodule

// File: doc/prg_cache.md
PRG_CACHE -- requirements
Module: prg_cache

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous active-high reset, sampled on clk rising edge.
REQ-003 SHALL have: prg_address  in  32  word address of the program fetch, from the PC stage.
REQ-004 SHALL have: flush  in  1  single-cycle request to invalidate all lines.
REQ-005 SHALL have: instruction  out  16  fetched instruction word.
REQ-006 SHALL have: p_cache_miss  out  1  high when instruction is not valid for the looked-up address.
REQ-007 SHALL have: mem_req  out  1  line-fill request to memory.
REQ-008 SHALL have: mem_addr  out  32  line base word address, with bits [1:0] = 0.
REQ-009 SHALL have: mem_ack  in  1  single-cycle acceptance of mem_req.
REQ-010 SHALL have: mem_valid  in  1  one fill beat on mem_data this cycle.
REQ-011 SHALL have: mem_data  in  16  fill beat data.

Function
REQ-012 SHALL be direct-mapped: 64 lines of 4 x 16-bit words; offset = addr[1:0], index = addr[7:2], tag = addr[31:8] (24 bits).
REQ-013 SHALL hold one valid bit per line in flops; the data and tag arrays need no reset.
REQ-014 SHALL use a lookup latency of 1: an address presented in cycle N produces instruction and p_cache_miss in cycle N+1.
REQ-015 SHALL compute the miss in N+1 as ~(valid[idx] & tag match) against the registered address of cycle N.
REQ-016 SHALL use FSM states IDLE, REQ, FILL and RESUME.
REQ-017 IDLE: if a lookup misses in cycle N+1, SHALL latch the registered address as miss_addr and enter REQ at N+2.
REQ-018 REQ: SHALL hold mem_req=1 and mem_addr={miss_addr[31:2],2'b00} until mem_ack; on mem_ack, SHALL drop mem_req and go to FILL in the next cycle.
REQ-019 FILL: each mem_valid SHALL write mem_data to word beat_cnt (2-bit, starting at 0) of line miss_addr[7:2], then increment beat_cnt.
REQ-020 On the 4th beat the FSM SHALL write tag = miss_addr[31:8], set valid unless flush_pending, and go to RESUME.
REQ-021 RESUME: SHALL present miss_addr to the arrays for one cycle, then return to IDLE; the lookup in the following cycle SHALL hit unless invalidated.
REQ-022 p_cache_miss SHALL be forced 1 in REQ, FILL and RESUME; prg_address SHALL be ignored in those states.
REQ-023 mem_valid and mem_ack SHALL be ignored outside FILL and REQ respectively.
REQ-024 flush in any state SHALL clear all 64 valid bits at the next edge.
REQ-025 flush during REQ or FILL SHALL set flush_pending: the fill SHALL complete without validating its line, and flush_pending SHALL clear on entering RESUME.
REQ-026 flush coinciding with the 4th beat SHALL leave the filled line invalid.
REQ-027 A hit in IDLE SHALL never stall; back-to-back sequential hits SHALL sustain one word per cycle.
REQ-028 instruction during a miss SHALL be don't-care; the consumer SHALL qualify it with p_cache_miss.

Reset
REQ-029 On rst, the block SHALL set: state IDLE, all valid bits 0, beat_cnt 0, flush_pending 0, mem_req 0, mem_addr 0, instruction 0x0000, lookup_armed 0.
REQ-030 p_cache_miss SHALL be 0 while lookup_armed=0; lookup_armed SHALL set one cycle after rst deasserts, so the first post-reset lookup is evaluated normally.
REQ-031 rst asserted mid-fill SHALL abort the fill, drop mem_req the following cycle, and leave no line valid.

Verification
REQ-032 Cold miss: after reset, prg_address=0x00000105 -> p_cache_miss=1; mem_req=1 with mem_addr=0x00000104; ack; beats 0xA0,0xA1,0xA2,0xA3 -> after RESUME, instruction=0xA1 and p_cache_miss=0.
REQ-033 Streaming hits: with line 0x104 filled, addresses 0x104..0x107 on consecutive cycles -> 0xA0..0xA3 on consecutive cycles with no miss.
REQ-034 Conflict eviction: fill 0x104, then fetch 0x00000204 (same index, different tag) -> miss and refill; re-fetching 0x104 then misses again.
REQ-035 Flush mid-fill: flush during the 2nd beat -> all 4 beats accepted, line not valid, next lookup of the same address misses and refetches.
REQ-036 Delayed ack: mem_ack held off for 10 cycles -> mem_req and mem_addr stable throughout and p_cache_miss held 1; stray mem_valid pulses in REQ are ignored.
REQ-037 Reset mid-fill: rst during FILL beat 1 -> state IDLE, mem_req=0, and no line valid afterwards.
